// File: rtl/prop_push_arbiter.sv
// ============================================================================
//  Module   : prop_push_arbiter
//  Purpose  : Round-robin arbiter for the propagation-queue push port, with
//             duplicate-literal suppression and conflict flush/hold control.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prop_push_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int LIT_WIDTH = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*LIT_WIDTH-1:0] req_lit,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         conflict,
    input  logic                         resume,
    input  logic                         q_full,
    output logic                         q_push,
    output logic [LIT_WIDTH-1:0]         q_din,
    output logic                         q_rst,
    output logic                         hold,
    output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
    output logic [CNT_WIDTH-1:0]         accept_count,
    output logic [CNT_WIDTH-1:0]         dup_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 last_valid_q, last_valid_d;
    logic [LIT_WIDTH-1:0] last_lit_q, last_lit_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] dup_q, dup_d;

    logic                 w_found;
    logic [IDX_W-1:0]     w_win;
    logic [LIT_WIDTH-1:0] w_lit;
    logic                 w_hs;
    logic                 w_dup;

    // Rotating priority scan starting at ptr; first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign w_lit = req_lit[int'(w_win)*LIT_WIDTH +: LIT_WIDTH];
    assign w_hs  = !rst && (state_q == ST_ACTIVE) && !conflict && w_found && !q_full;
    assign w_dup = last_valid_q && (w_lit == last_lit_q);

    assign req_ready    = w_hs ? (NUM_REQ'(1) << w_win) : '0;
    assign q_push       = w_hs && !w_dup;
    assign q_din        = w_lit;
    assign grant_idx    = w_win;
    assign q_rst        = rst || (state_q == ST_FLUSH);
    assign hold         = !rst && (state_q != ST_ACTIVE);
    assign accept_count = acc_q;
    assign dup_count    = dup_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        last_valid_d = last_valid_q;
        last_lit_d   = last_lit_q;
        acc_d        = acc_q;
        dup_d        = dup_q;
        case (state_q)
            ST_ACTIVE: begin
                if (conflict) begin
                    state_d = ST_FLUSH;
                end else if (w_hs) begin
                    ptr_d = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                    if (w_dup) begin
                        if (dup_q != '1) dup_d = dup_q + 1'b1;
                    end else begin
                        last_valid_d = 1'b1;
                        last_lit_d   = w_lit;
                        if (acc_q != '1) acc_d = acc_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                last_valid_d = 1'b0;
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                if (resume) state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACTIVE;
            ptr_q        <= '0;
            last_valid_q <= 1'b0;
            last_lit_q   <= '0;
            acc_q        <= '0;
            dup_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            last_valid_q <= last_valid_d;
            last_lit_q   <= last_lit_d;
            acc_q        <= acc_d;
            dup_q        <= dup_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prop_push_arbiter.sv
// ============================================================================
//  Module   : tb_prop_push_arbiter
//  Purpose  : Scoreboard bench for prop_push_arbiter against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prop_push_arbiter;

    localparam int N  = 4;
    localparam int LW = 6;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*LW-1:0] req_lit;
    logic [N-1:0]    req_ready;
    logic            conflict, resume, q_full;
    logic            q_push, q_rst, hold;
    logic [LW-1:0]   q_din;
    logic [1:0]      grant_idx;
    logic [CW-1:0]   accept_count, dup_count;

    prop_push_arbiter #(.NUM_REQ(N), .LIT_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_lit(req_lit),
        .req_ready(req_ready), .conflict(conflict), .resume(resume),
        .q_full(q_full), .q_push(q_push), .q_din(q_din), .q_rst(q_rst),
        .hold(hold), .grant_idx(grant_idx), .accept_count(accept_count),
        .dup_count(dup_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  ready;
        logic          push;
        logic [LW-1:0] din;
        logic [1:0]    grant;
        logic          qrst;
        logic          hold;
        logic [CW-1:0] acc;
        logic [CW-1:0] dup;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: mode 0 = running, 1 = clearing, 2 = waiting for resume.
    int      m_mode = 0;
    int      m_ptr  = 0;
    bit      m_have_last = 0;
    int      m_last = 0;
    longint  m_acc = 0;
    longint  m_dup = 0;
    localparam longint CMAX = (64'd1 << CW) - 1;

    task automatic model_cycle();
        exp_t e;
        int   w;
        int   lit;
        e.ready = '0; e.push = 0; e.din = '0; e.grant = '0;
        e.qrst = 0; e.hold = 0;
        e.acc = CW'(m_acc); e.dup = CW'(m_dup);
        if (rst) begin
            e.qrst = 1;
            m_mode = 0; m_ptr = 0; m_have_last = 0; m_last = 0; m_acc = 0; m_dup = 0;
        end else if (m_mode == 1) begin
            e.qrst = 1; e.hold = 1;
            m_have_last = 0;
            m_mode = 2;
        end else if (m_mode == 2) begin
            e.hold = 1;
            if (resume) m_mode = 0;
        end else if (conflict) begin
            m_mode = 1;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0 && !q_full) begin
                lit = int'(req_lit[w*LW +: LW]);
                e.ready = N'(1) << w;
                e.grant = 2'(w);
                if (m_have_last && lit == m_last) begin
                    if (m_dup < CMAX) m_dup++;
                end else begin
                    e.push = 1; e.din = LW'(lit);
                    m_have_last = 1; m_last = lit;
                    if (m_acc < CMAX) m_acc++;
                end
                m_ptr = (w + 1) % N;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*LW-1:0] l,
                        input logic c, input logic rs, input logic f);
        @(negedge clk);
        rst = r; req_valid = v; req_lit = l; conflict = c; resume = rs; q_full = f;
        #1 model_cycle();
    endtask

    function automatic logic [N*LW-1:0] lits(input int a, input int b, input int c, input int d);
        return {LW'(d), LW'(c), LW'(b), LW'(a)};
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle is a presented response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("req_ready", longint'(req_ready), longint'(e.ready));
                chk("q_push", longint'(q_push), longint'(e.push));
                if (e.push) chk("q_din", longint'(q_din), longint'(e.din));
                if (e.ready != '0) chk("grant_idx", longint'(grant_idx), longint'(e.grant));
                chk("q_rst", longint'(q_rst), longint'(e.qrst));
                chk("hold", longint'(hold), longint'(e.hold));
                chk("accept_count", longint'(accept_count), longint'(e.acc));
                chk("dup_count", longint'(dup_count), longint'(e.dup));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1; req_valid = '0; req_lit = '0; conflict = 0; resume = 0; q_full = 0;
        step(1, 4'b0000, '0, 0, 0, 0);
        step(1, 4'b0000, '0, 0, 0, 0);
        step(0, 4'b0000, '0, 0, 0, 0);
        // All four requesters held: grants rotate 0..3.
        repeat (4) step(0, 4'b1111, lits(5, 6, 7, 8), 0, 0, 0);
        // Repeated literal from one source: one push, then duplicates.
        repeat (3) step(0, 4'b0100, lits(0, 0, 9, 0), 0, 0, 0);
        // Queue full blocks handshakes; ptr stays at 3 so req0 wins after.
        repeat (2) step(0, 4'b0011, lits(11, 12, 0, 0), 0, 0, 1);
        step(0, 4'b0011, lits(11, 12, 0, 0), 0, 0, 0);
        // Conflict with req1 pending, flush, hold, resume.
        step(0, 4'b0010, lits(0, 12, 0, 0), 1, 0, 0);
        step(0, 4'b0010, lits(0, 12, 0, 0), 1, 1, 0);
        step(0, 4'b0010, lits(0, 12, 0, 0), 1, 0, 0);
        step(0, 4'b0010, lits(0, 12, 0, 0), 0, 0, 0);
        step(0, 4'b0010, lits(0, 12, 0, 0), 0, 1, 0);
        // Pre-conflict last literal (11) must be pushed again.
        step(0, 4'b0001, lits(11, 0, 0, 0), 0, 0, 0);
        // Wrap: bring ptr to 3, then req3 then req0.
        step(0, 4'b0100, lits(0, 0, 20, 0), 0, 0, 0);
        step(0, 4'b1001, lits(22, 0, 0, 21), 0, 0, 0);
        step(0, 4'b1001, lits(22, 0, 0, 21), 0, 0, 0);
        // Randomised traffic with small literal range to provoke duplicates.
        for (int i = 0; i < 600; i++) begin
            logic [N*LW-1:0] l;
            for (int j = 0; j < N; j++) l[j*LW +: LW] = LW'($urandom_range(0, 3));
            step(($urandom_range(0, 99) == 0), N'($urandom), l,
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0));
        end
        step(0, '0, '0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prop_push_arbiter.md
Name: prop_push_arbiter

Overview:
Shares the single push port of the propagation queue between NUM_REQ implication sources (clause evaluators) using round-robin arbitration. It accepts at most one literal per cycle and suppresses back-to-back duplicate literals. On a conflict it clears the queue and holds off all sources until the solver signals resume. It sits between the clause-evaluation units and the propagation queue's push/din/rst/full pins.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
LIT_WIDTH, 6, literal width, matching the queue
CNT_WIDTH, 16, width of the duplicate and accepted statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  requester i has a literal
req_lit  in  NUM_REQ*LIT_WIDTH  literal of requester i, held in bits [i*LIT_WIDTH +: LIT_WIDTH]
req_ready  out  NUM_REQ  one-hot or zero; handshake with requester i completes when valid[i]&&ready[i]
conflict  in  1  single-cycle conflict pulse from the solver
resume  in  1  solver restarts propagation after a conflict
q_full  in  1  queue full flag
q_push  out  1  queue push
q_din  out  LIT_WIDTH  literal to queue
q_rst  out  1  queue clear
hold  out  1  high while in FLUSH or HOLD
grant_idx  out  $clog2(NUM_REQ)  index of the current winner; valid when any req_ready bit is high
accept_count  out  CNT_WIDTH  literals actually pushed since reset
dup_count  out  CNT_WIDTH  literals accepted but dropped as duplicates since reset

Behaviour:
- FSM states: ACTIVE, FLUSH, HOLD. Reset -> ACTIVE.
- Reset values: ptr=0, last_valid=0, last_lit=0, accept_count=0, dup_count=0. While rst is high: q_rst=1, q_push=0, req_ready=0, hold=0.
- req_ready, q_push, q_din and grant_idx are combinational from the current inputs and state; there is no push latency.
- ACTIVE with conflict=0:
  - Winner = first i with req_valid[i]=1, scanning ptr, ptr+1, ... with wrap modulo NUM_REQ.
  - req_ready[winner]=1 only if q_full=0; all other ready bits are 0.
  - If there is no valid request, or q_full=1, no handshake occurs and ptr is unchanged.
- On a handshake with literal L:
  - Duplicate (last_valid && L==last_lit): q_push=0 and dup_count increments.
  - Otherwise: q_push=1, q_din=L, last_lit<=L, last_valid<=1, and accept_count increments.
  - In both cases ptr <= (winner+1) mod NUM_REQ.
- A duplicate still requires q_full=0 in order to be accepted.
- conflict=1 in ACTIVE has priority over any request:
  - No ready, no push that cycle.
  - Next state FLUSH.
- FLUSH lasts exactly 1 cycle:
  - q_rst=1, hold=1, no ready.
  - last_valid<=0, ptr unchanged.
  - Next state HOLD.
- HOLD: hold=1, no ready, q_rst=0. resume=1 -> ACTIVE next cycle; the first grant is possible in the cycle after resume.
- conflict in FLUSH or HOLD is ignored.
- resume outside HOLD is ignored.
- Counters saturate at all-ones; they do not wrap.
- Synchronous rst in any state returns to ACTIVE with reset values the next cycle. The queue is also cleared, because q_rst=1 during rst.
- req_lit of non-winners is ignored. Requesters must hold valid and lit until ready; the arbiter does not rely on this beyond the current cycle.

Test Plan:
- Reset -> accept_count=0, dup_count=0, ptr=0, hold=0; q_rst=1 during rst, 0 after.
- All 4 valid with literals 5,6,7,8, held for 4 cycles -> grants 0,1,2,3 in order; q_din 5,6,7,8; accept_count=4.
- Only req2 valid with lit 9 for 3 consecutive handshakes -> first pushes 9; next two give ready=1, q_push=0; dup_count=2, accept_count=1.
- q_full=1 with req0 and req1 valid -> req_ready=0 and ptr unchanged. Drop q_full -> req0 granted first.
- conflict pulse in the same cycle as a valid req1 -> no push. Next cycle q_rst=1 and hold=1, then hold stays high. resume -> next cycle ACTIVE. Re-pushing the pre-conflict last literal is pushed, not dropped as a duplicate.
- NUM_REQ=4, ptr=3, req3 and req0 valid -> req3 granted, ptr wraps to 0. Next cycle req0 granted.
